// File: rtl/data_bus.sv
// data_bus: data-side bridge from the core's load/store port to RAM and a
// small MMIO block (machine timer + UART transmitter with TX FIFO).
// Read data always returns one cycle after the address is presented.
module data_bus #(
    parameter logic [31:0] RAM_BASE     = 32'h0000_0000,
    parameter int unsigned RAM_WORDS    = 4096,
    parameter logic [31:0] MMIO_BASE    = 32'h1000_0000,
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 8,
    localparam int unsigned AW          = $clog2(RAM_WORDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   d_addr,
    input  logic [3:0]    d_we,
    input  logic [31:0]   d_wr_data,
    output logic [31:0]   d_rd_data,
    output logic [AW-1:0] ram_addr,
    output logic [3:0]    ram_we,
    output logic [31:0]   ram_wr_data,
    input  logic [31:0]   ram_rd_data,
    output logic          uart_tx,
    output logic          timer_irq
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [29:0]   RAM_WORDS_W = 30'(RAM_WORDS);
    localparam logic [PW:0]   FIFO_FULL   = (PW + 1)'(FIFO_DEPTH);

    localparam logic [3:0] OFF_TXDATA = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h1;
    localparam logic [3:0] OFF_MTLO   = 4'h2;
    localparam logic [3:0] OFF_MTHI   = 4'h3;
    localparam logic [3:0] OFF_CMPLO  = 4'h4;
    localparam logic [3:0] OFF_CMPHI  = 4'h5;

    typedef enum logic [1:0] {SEL_NONE, SEL_RAM, SEL_MMIO} sel_e;
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_e;

    function automatic logic [31:0] byte_merge(input logic [31:0] base,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  be);
        logic [31:0] r;
        r = base;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = wdata[8*b +: 8];
        return r;
    endfunction

    // ---------------- address decode (word granular) ----------------
    logic [29:0] ram_woff, mmio_woff;
    logic        ram_hit, mmio_hit, mmio_wr;
    logic [3:0]  mmio_word;
    logic        unused_addr_lsbs;

    assign ram_woff  = d_addr[31:2] - RAM_BASE[31:2];
    assign mmio_woff = d_addr[31:2] - MMIO_BASE[31:2];
    assign ram_hit   = (d_addr[31:2] >= RAM_BASE[31:2]) && (ram_woff < RAM_WORDS_W);
    // RAM wins if the two windows were ever configured to overlap
    assign mmio_hit  = !ram_hit && (d_addr[31:2] >= MMIO_BASE[31:2]) && (mmio_woff[29:4] == '0);
    assign mmio_word = mmio_woff[3:0];
    assign mmio_wr   = mmio_hit && (d_we != 4'b0);
    assign unused_addr_lsbs = ^d_addr[1:0];

    assign ram_addr    = ram_woff[AW-1:0];
    assign ram_we      = ram_hit ? d_we : 4'b0;
    assign ram_wr_data = d_wr_data;

    // ---------------- machine timer ----------------
    logic [63:0] mtime_q, mtime_d, mtime_inc, mtimecmp_q, mtimecmp_d;
    logic        timer_irq_q;

    assign mtime_inc = mtime_q + 64'd1;

    // Next timer state: free-running increment, overridden byte-wise by writes
    always_comb begin
        mtime_d    = mtime_inc;
        mtimecmp_d = mtimecmp_q;
        if (mmio_wr) begin
            case (mmio_word)
                OFF_MTLO:  mtime_d[31:0]     = byte_merge(mtime_inc[31:0],  d_wr_data, d_we);
                OFF_MTHI:  mtime_d[63:32]    = byte_merge(mtime_inc[63:32], d_wr_data, d_we);
                OFF_CMPLO: mtimecmp_d[31:0]  = byte_merge(mtimecmp_q[31:0],  d_wr_data, d_we);
                OFF_CMPHI: mtimecmp_d[63:32] = byte_merge(mtimecmp_q[63:32], d_wr_data, d_we);
                default: ;
            endcase
        end
    end

    // Timer registers; the interrupt compares the pre-edge values
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mtime_q     <= '0;
            mtimecmp_q  <= '1;
            timer_irq_q <= 1'b0;
        end else begin
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            timer_irq_q <= (mtime_q >= mtimecmp_q);
        end
    end

    assign timer_irq = timer_irq_q;

    // ---------------- TX FIFO ----------------
    logic [7:0]  fifo_mem [FIFO_DEPTH];
    logic [PW:0] wptr_q, rptr_q, fifo_level;
    logic        fifo_full, fifo_empty, push, pop;
    logic [3:0]  level_sat;
    tx_state_e   tx_state_q;

    assign fifo_level = wptr_q - rptr_q;
    assign fifo_empty = (wptr_q == rptr_q);
    assign fifo_full  = (fifo_level == FIFO_FULL);
    assign level_sat  = (int'(fifo_level) > 15) ? 4'hF : 4'(fifo_level);
    // full/empty come from pre-edge pointers, so a pop cannot rescue a push into a full FIFO
    assign push = mmio_hit && (mmio_word == OFF_TXDATA) && d_we[0] && !fifo_full;
    assign pop  = (tx_state_q == S_IDLE) && !fifo_empty;

    // FIFO storage; no reset needed, the pointers define what is valid
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wptr_q[PW-1:0]] <= d_wr_data[7:0];
    end

    // FIFO pointers (one extra wrap bit distinguishes full from empty)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    // ---------------- UART transmitter ----------------
    logic [CW-1:0] baud_cnt_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic          uart_tx_q;
    logic          baud_end, tx_busy;

    assign baud_end = (baud_cnt_q == BAUD_LAST);
    assign tx_busy  = (tx_state_q != S_IDLE);

    // Frame FSM; the line level is registered from the state, so it trails by one cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_q <= S_IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            uart_tx_q  <= 1'b1;
        end else begin
            case (tx_state_q)
                S_START: uart_tx_q <= 1'b0;
                S_DATA:  uart_tx_q <= shift_q[bit_idx_q];
                default: uart_tx_q <= 1'b1;
            endcase
            if (tx_state_q != S_IDLE)
                baud_cnt_q <= baud_end ? '0 : baud_cnt_q + 1'b1;
            case (tx_state_q)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        shift_q    <= fifo_mem[rptr_q[PW-1:0]];
                        baud_cnt_q <= '0;
                        tx_state_q <= S_START;
                    end
                end
                S_START: begin
                    if (baud_end) begin
                        bit_idx_q  <= '0;
                        tx_state_q <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (baud_end) begin
                        if (bit_idx_q == 3'd7) tx_state_q <= S_STOP;
                        else                   bit_idx_q  <= bit_idx_q + 1'b1;
                    end
                end
                default: begin
                    if (baud_end) tx_state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign uart_tx = uart_tx_q;

    // ---------------- read path ----------------
    sel_e        sel_d, sel_q;
    logic [31:0] mmio_rdata_d, mmio_rdata_q;

    assign sel_d = ram_hit ? SEL_RAM : (mmio_hit ? SEL_MMIO : SEL_NONE);

    // MMIO read mux over pre-edge state; reserved and write-only words read 0
    always_comb begin
        mmio_rdata_d = '0;
        case (mmio_word)
            OFF_STATUS: mmio_rdata_d = {24'd0, level_sat, 1'b0, tx_busy, fifo_empty, fifo_full};
            OFF_MTLO:   mmio_rdata_d = mtime_q[31:0];
            OFF_MTHI:   mmio_rdata_d = mtime_q[63:32];
            OFF_CMPLO:  mmio_rdata_d = mtimecmp_q[31:0];
            OFF_CMPHI:  mmio_rdata_d = mtimecmp_q[63:32];
            default:    mmio_rdata_d = '0;
        endcase
    end

    // Capture region and MMIO value at the edge the address is sampled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_q        <= SEL_NONE;
            mmio_rdata_q <= '0;
        end else begin
            sel_q        <= sel_d;
            mmio_rdata_q <= mmio_rdata_d;
        end
    end

    // Return mux: RAM data arrives from the synchronous RAM this cycle
    always_comb begin
        case (sel_q)
            SEL_RAM:  d_rd_data = ram_rd_data;
            SEL_MMIO: d_rd_data = mmio_rdata_q;
            default:  d_rd_data = '0;
        endcase
    end

endmodule
